// File: rtl/fmap_scan_reader_pkg.sv
// rtl/fmap_scan_reader_pkg.sv - shared types for the feature-map tile scan sequencers
package fmap_scan_reader_pkg;

    localparam int FMAP_RAM_WIDTH = 16;
    localparam int FMAP_ADDR_BITS = 10;
    localparam int FMAP_DIM_BITS  = 6;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_RUN,
        SCAN_DRAIN
    } scan_state_t;

    // Tile descriptor shared with the write-side loader.
    typedef struct packed {
        logic [FMAP_ADDR_BITS-1:0] base;
        logic [FMAP_DIM_BITS-1:0]  rows;
        logic [FMAP_DIM_BITS-1:0]  cols;
        logic [FMAP_DIM_BITS-1:0]  chans;
    } tile_desc_t;

    // A tile with any zero dimension holds no words.
    function automatic logic tile_is_empty(input logic [FMAP_DIM_BITS-1:0] r,
                                           input logic [FMAP_DIM_BITS-1:0] c,
                                           input logic [FMAP_DIM_BITS-1:0] ch);
        return (r == '0) || (c == '0) || (ch == '0);
    endfunction

endpackage

// File: rtl/fmap_scan_reader_if.sv
// rtl/fmap_scan_reader_if.sv - output word stream with row/tile markers
interface fmap_scan_reader_if #(
    parameter int RAM_WIDTH = 16
);
    logic [RAM_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_eol;
    logic                 out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_eol,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_eol,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fmap_scan_reader_tile_counter3.sv
// rtl/fmap_scan_reader_tile_counter3.sv - nested col/row/chan counter with eol/last flags
module tile_counter3 #(
    parameter int DIM_BITS = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                advance,
    input  logic [DIM_BITS-1:0] cols_m1,
    input  logic [DIM_BITS-1:0] rows_m1,
    input  logic [DIM_BITS-1:0] chans_m1,
    output logic                eol,
    output logic                last
);

    localparam logic [DIM_BITS-1:0] DIM_ONE = 1;

    logic [DIM_BITS-1:0] col;
    logic [DIM_BITS-1:0] row;
    logic [DIM_BITS-1:0] chan;

    assign eol  = (col == cols_m1);
    assign last = eol && (row == rows_m1) && (chan == chans_m1);

    // Column steps fastest, carrying into row and then channel.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            col  <= '0;
            row  <= '0;
            chan <= '0;
        end else if (advance) begin
            if (col == cols_m1) begin
                col <= '0;
                if (row == rows_m1) begin
                    row  <= '0;
                    chan <= (chan == chans_m1) ? '0 : chan + DIM_ONE;
                end else begin
                    row <= row + DIM_ONE;
                end
            end else begin
                col <= col + DIM_ONE;
            end
        end
    end

endmodule

// File: rtl/fmap_scan_reader.sv
// rtl/fmap_scan_reader.sv - walks a tile in the feature-map RAM and streams its words
module fmap_scan_reader
    import fmap_scan_reader_pkg::*;
#(
    parameter int RAM_WIDTH     = FMAP_RAM_WIDTH,
    parameter int RAM_ADDR_BITS = FMAP_ADDR_BITS,
    parameter int DIM_BITS      = FMAP_DIM_BITS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_addr,
    input  logic [DIM_BITS-1:0]      rows,
    input  logic [DIM_BITS-1:0]      cols,
    input  logic [DIM_BITS-1:0]      chans,
    output logic [RAM_ADDR_BITS-1:0] read_address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic                     busy,
    output logic                     done,
    fmap_scan_reader_if.master       stream
);

    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;
    localparam logic [DIM_BITS-1:0]      DIM_ONE  = 1;

    scan_state_t              state;
    scan_state_t              next_state;
    tile_desc_t               desc;
    logic [RAM_ADDR_BITS-1:0] offset;
    logic                     ld;
    logic                     cnt_eol;
    logic                     cnt_last;
    logic                     start_ok;

    // The output register may take a new word when empty or being drained this cycle.
    assign ld           = (state == SCAN_RUN) && (!stream.out_valid || stream.out_ready);
    assign start_ok     = (state == SCAN_IDLE) && start;
    assign read_address = desc.base + offset;
    assign busy         = (state != SCAN_IDLE);

    tile_counter3 #(
        .DIM_BITS (DIM_BITS)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (start_ok),
        .advance  (ld),
        .cols_m1  (desc.cols - DIM_ONE),
        .rows_m1  (desc.rows - DIM_ONE),
        .chans_m1 (desc.chans - DIM_ONE),
        .eol      (cnt_eol),
        .last     (cnt_last)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SCAN_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: empty tiles never leave IDLE; DRAIN waits for the final handshake.
    always_comb begin
        next_state = state;
        case (state)
            SCAN_IDLE: begin
                if (start && !tile_is_empty(rows, cols, chans)) begin
                    next_state = SCAN_RUN;
                end
            end
            SCAN_RUN: begin
                if (ld && cnt_last) begin
                    next_state = SCAN_DRAIN;
                end
            end
            SCAN_DRAIN: begin
                if (stream.out_valid && stream.out_ready) begin
                    next_state = SCAN_IDLE;
                end
            end
            default: next_state = SCAN_IDLE;
        endcase
    end

    // Descriptor latch, address offset, output register and done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            desc             <= '0;
            offset           <= '0;
            stream.out_data  <= '0;
            stream.out_valid <= 1'b0;
            stream.out_eol   <= 1'b0;
            stream.out_last  <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SCAN_IDLE: begin
                    if (start) begin
                        desc.base  <= base_addr;
                        desc.rows  <= rows;
                        desc.cols  <= cols;
                        desc.chans <= chans;
                        offset     <= '0;
                        done       <= tile_is_empty(rows, cols, chans);
                    end
                end
                SCAN_RUN: begin
                    if (ld) begin
                        stream.out_data  <= ram_data;
                        stream.out_valid <= 1'b1;
                        stream.out_eol   <= cnt_eol;
                        stream.out_last  <= cnt_last;
                        offset           <= offset + ADDR_ONE;
                    end
                end
                SCAN_DRAIN: begin
                    if (stream.out_valid && stream.out_ready) begin
                        stream.out_valid <= 1'b0;
                        stream.out_eol   <= 1'b0;
                        stream.out_last  <= 1'b0;
                        done             <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_scan_reader.sv
// tb/tb_fmap_scan_reader.sv - self-checking bench for fmap_scan_reader
module tb_fmap_scan_reader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [5:0]  rows;
    logic [5:0]  cols;
    logic [5:0]  chans;
    logic [9:0]  read_address;
    logic [15:0] ram_data;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:1023];

    fmap_scan_reader_if #(.RAM_WIDTH(16)) s_if ();

    fmap_scan_reader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .rows         (rows),
        .cols         (cols),
        .chans        (chans),
        .read_address (read_address),
        .ram_data     (ram_data),
        .busy         (busy),
        .done         (done),
        .stream       (s_if)
    );

    assign ram_data = mem[read_address];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] d;
        logic        eol;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          done_tokens = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_data;
    logic        prev_eol;
    logic        prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: the tile is a linear run of words from base, modulo RAM size.
    task automatic model_push(input int b, input int r, input int c, input int ch);
        int n;
        exp_t e;
        n = r * c * ch;
        for (int k = 0; k < n; k++) begin
            e.d    = mem[(b + k) % 1024];
            e.eol  = ((k + 1) % c) == 0;
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
        done_tokens++;
    endtask

    // Checks every output word, stall stability and done/busy relation each cycle.
    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (stall_prev && s_if.out_valid) begin
                chk("stall_hold_data", s_if.out_data, prev_data);
                chk("stall_hold_marks", {s_if.out_eol, s_if.out_last}, {prev_eol, prev_last});
            end
            if (s_if.out_valid && s_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", s_if.out_data, 32'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_data", s_if.out_data, e.d);
                    chk("word_eol", s_if.out_eol, e.eol);
                    chk("word_last", s_if.out_last, e.last);
                end
            end
            if (done) begin
                chk("done_expected", done_tokens > 0, 1);
                chk("done_all_words_out", exp_q.size(), 0);
                if (done_tokens > 0) done_tokens--;
            end
            stall_prev = s_if.out_valid && !s_if.out_ready;
            prev_data  = s_if.out_data;
            prev_eol   = s_if.out_eol;
            prev_last  = s_if.out_last;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_tile(input int b, input int r, input int c, input int ch);
        start     = 1'b1;
        base_addr = 10'(b);
        rows      = 6'(r);
        cols      = 6'(c);
        chans     = 6'(ch);
        model_push(b, r, c, ch);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound, input logic toggle);
        int i;
        for (i = 0; i < bound; i++) begin
            if (done) break;
            if (toggle) s_if.out_ready = ~s_if.out_ready;
            step();
        end
        if (i == bound) chk({name, "_timeout"}, 0, 1);
        s_if.out_ready = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        reset          = 1'b1;
        start          = 1'b0;
        base_addr      = '0;
        rows           = '0;
        cols           = '0;
        chans          = '0;
        s_if.out_ready = 1'b1;
        step();
        step();
        chk("rst_addr", read_address, 0);
        chk("rst_data", s_if.out_data, 0);
        chk("rst_flags", {s_if.out_valid, s_if.out_eol, s_if.out_last, busy, done}, 0);
        reset = 1'b0;
        step();

        // 2x3x1 tile at 0x010, ready high: cycle-exact literal expectations.
        start_tile(16'h010, 2, 3, 1);
        chk("t1_busy_c1", busy, 1);
        chk("t1_addr_c1", read_address, 10'h010);
        chk("t1_valid_c1", s_if.out_valid, 0);
        for (int c = 2; c <= 8; c++) begin
            step();
            if (c <= 7) begin
                chk("t1_valid", s_if.out_valid, 1);
                chk("t1_data", s_if.out_data, 16'h010 + 16'(c - 2));
                chk("t1_eol", s_if.out_eol, (c == 4 || c == 7));
                chk("t1_last", s_if.out_last, (c == 7));
            end else begin
                chk("t1_done_c8", done, 1);
                chk("t1_busy_c8", busy, 0);
                chk("t1_valid_c8", s_if.out_valid, 0);
            end
        end
        step();
        chk("t1_done_pulse", done, 0);

        // Same tile with ready toggling.
        start_tile(16'h010, 2, 3, 1);
        wait_done("t2", 60, 1'b1);

        // Address wrap at the top of the RAM.
        start_tile(16'h3FE, 1, 4, 1);
        chk("t3_addr0", read_address, 10'h3FE);
        step();
        chk("t3_addr1", read_address, 10'h3FF);
        chk("t3_data0", s_if.out_data, 16'h3FE);
        step();
        chk("t3_addr2", read_address, 10'h000);
        step();
        chk("t3_addr3", read_address, 10'h001);
        chk("t3_data2", s_if.out_data, 16'h000);
        wait_done("t3", 20, 1'b0);

        // Empty tile.
        start_tile(16'h050, 3, 0, 2);
        chk("t4_done_c1", done, 1);
        chk("t4_busy_c1", busy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_idle", {done, busy, s_if.out_valid}, 0);
        end

        // Reset after the third handshake of a 2x2x2 tile.
        start_tile(16'h100, 2, 2, 2);
        step();
        step();
        step();
        step();
        reset = 1'b1;
        exp_q.delete();
        done_tokens = 0;
        step();
        reset = 1'b0;
        chk("t5_rst_addr", read_address, 0);
        chk("t5_rst_data", s_if.out_data, 0);
        chk("t5_rst_flags", {s_if.out_valid, s_if.out_eol, s_if.out_last, busy, done}, 0);
        step();
        start_tile(16'h100, 2, 2, 2);
        wait_done("t5", 40, 1'b0);

        // Start while running with another base must be ignored.
        start_tile(16'h010, 2, 3, 1);
        step();
        start     = 1'b1;
        base_addr = 10'h200;
        rows      = 6'd1;
        cols      = 6'd1;
        chans     = 6'd1;
        step();
        start = 1'b0;
        wait_done("t6", 40, 1'b0);
        step();
        chk("t6_idle_after", {busy, s_if.out_valid}, 0);

        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_done_tokens", done_tokens, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
